change_capture: RTL and testbench

Capture-side counterpart to the stimulus/hierarchy test modules. It samples a small signal bus every clock and detects any value change. Each change is recorded as a timestamped event in an internal FIFO, and the events are read out over a valid/ready port. It sits at the top of a test harness, where a checker or host model drains the events in order.

---
 rtl/change_capture.sv | 84 ++++++++
 tb/tb_change_capture.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/change_capture.sv
// Samples a small bus every clock and queues a timestamped {ts, value} entry
// on every change. Entries drain in order over a show-ahead valid/ready port.
module change_capture #(
  parameter int WIDTH    = 2,
  parameter int TS_WIDTH = 16,
  parameter int DEPTH    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      clear,
  input  logic [WIDTH-1:0]          sample_in,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [TS_WIDTH+WIDTH-1:0] rd_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic [7:0]                drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = TS_WIDTH + WIDTH;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  logic [TS_WIDTH-1:0] ts;
  logic [WIDTH-1:0]    prev;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [EW-1:0]       mem [DEPTH];
  logic [EW-1:0]       entry;
  logic                full, change, pop, push, drop;

  assign rd_valid = (count != '0);
  assign full     = (count == FULL_CNT);
  assign change   = enable && !clear && (sample_in != prev);
  assign pop      = rd_valid && rd_ready && !clear;
  // A full FIFO still accepts a new entry when the head leaves in the same cycle.
  assign push     = change && (!full || pop);
  assign drop     = change && full && !pop;
  assign entry    = {ts, sample_in};

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts         <= '0;
      prev       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
      rd_data    <= '0;
    end else if (clear) begin
      ts         <= '0;
      prev       <= sample_in;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (enable) begin
        ts   <= ts + TS_WIDTH'(1);
        prev <= sample_in;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + ONE_CNT;
      else if (!push && pop) count <= count - ONE_CNT;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
      // rd_data is a register holding the head; it keeps its old value when empty.
      if (pop) begin
        if (count != ONE_CNT) rd_data <= mem[rd_ptr + AW'(1)];
        else if (push)        rd_data <= entry;
      end else if (push && count == '0) begin
        rd_data <= entry;
      end
    end
  end
endmodule

// File: tb/tb_change_capture.sv
// Randomized + directed bench for change_capture: a queue-based reference model
// predicts entries, a negedge monitor compares every accepted head.
module tb_change_capture;
  localparam int W  = 2;
  localparam int TW = 4;
  localparam int D  = 8;
  localparam int E  = TW + W;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0, rst_n = 1'b0, enable = 1'b0, clear = 1'b0, rd_ready = 1'b0;
  logic [W-1:0]  sample_in = '0;
  logic          rd_valid, overflow;
  logic [E-1:0]  rd_data;
  logic [CW-1:0] count;
  logic [7:0]    drop_count;

  change_capture #(.WIDTH(W), .TS_WIDTH(TW), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .sample_in(sample_in),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .count(count),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;
  logic [E-1:0] exp_q[$];
  int m_ts, m_prev, m_cnt, m_drop, m_ovf;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ts = 0; m_prev = 0; m_cnt = 0; m_drop = 0; m_ovf = 0;
    exp_q.delete();
  endtask

  // Drive one cycle of inputs, advance the model across the edge, check status.
  task automatic step(input bit en, input int s, input bit rdy, input bit clr);
    bit pop, chg, push;
    logic [TW-1:0] t;
    logic [W-1:0]  v;
    enable = en; sample_in = s[W-1:0]; rd_ready = rdy; clear = clr;
    pop  = rdy && (m_cnt > 0) && !clr;
    chg  = en && !clr && (s != m_prev);
    push = 0;
    if (clr) begin
      model_reset();
      m_prev = s;
    end else begin
      if (chg) begin
        if (m_cnt < D || pop) begin
          t = m_ts[TW-1:0]; v = s[W-1:0];
          exp_q.push_back({t, v});
          push = 1;
        end else begin
          m_ovf = 1;
          if (m_drop < 255) m_drop++;
        end
      end
      m_cnt = m_cnt + int'(push) - int'(pop);
      if (en) begin
        m_ts = (m_ts + 1) % (1 << TW);
        m_prev = s;
      end
    end
    @(posedge clk); #1;
    chk("count", int'(count), m_cnt);
    chk("overflow", int'(overflow), m_ovf);
    chk("drop_count", int'(drop_count), m_drop);
    chk("rd_valid", int'(rd_valid), int'(m_cnt != 0));
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * D + 2 && m_cnt != 0; i++) step(1'b1, int'(sample_in), 1'b1, 1'b0);
    chk("drained", int'(count), 0);
  endtask

  // Scoreboard side: compare each head the DUT hands over.
  always @(negedge clk) begin
    if (rst_n && rd_valid && rd_ready && !clear) begin
      if (exp_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL rd_data: unexpected entry %0h, none expected", rd_data);
      end else begin
        chk("rd_data", int'(rd_data), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    model_reset();
    #2;
    chk("reset rd_valid", int'(rd_valid), 0);
    chk("reset rd_data", int'(rd_data), 0);
    chk("reset count", int'(count), 0);
    chk("reset overflow", int'(overflow), 0);
    chk("reset drop_count", int'(drop_count), 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // basic capture: changes at ts=3 and ts=4
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(1, 1, 0, 0); step(1, 2, 0, 0);
    chk("basic count", int'(count), 2);
    chk("basic head0", int'(rd_data), int'({4'd3, 2'b01}));
    step(1, 2, 1, 0);
    chk("basic head1", int'(rd_data), int'({4'd4, 2'b10}));
    drain();

    // overflow: 10 changes into 8 slots
    step(1, 0, 0, 1);
    for (int k = 0; k < 10; k++) step(1, (k % 2 == 0) ? 1 : 0, 0, 0);
    chk("ovf count", int'(count), 8);
    chk("ovf flag", int'(overflow), 1);
    chk("ovf drops", int'(drop_count), 2);
    chk("ovf head ts", int'(rd_data[E-1:W]), 0);
    drain();

    // full with simultaneous pop
    step(1, 0, 0, 1);
    for (int k = 0; k < 8; k++) step(1, (k % 2 == 0) ? 1 : 0, 0, 0);
    step(1, 1, 1, 0);
    chk("fullpop count", int'(count), 8);
    chk("fullpop ovf", int'(overflow), 0);
    drain();

    // enable gating
    step(1, 0, 0, 1);
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 3, 0, 0); step(0, 1, 0, 0);
    chk("gated count", int'(count), 0);
    step(1, 1, 0, 0);
    chk("reenable count", int'(count), 1);
    chk("reenable entry", int'(rd_data), int'({4'd2, 2'b01}));
    drain();

    // timestamp wrap, then clear
    step(1, 0, 0, 1);
    for (int k = 0; k < 17; k++) step(1, 0, 0, 0);
    step(1, 2, 0, 0);
    chk("wrap entry", int'(rd_data), int'({4'd1, 2'b10}));
    step(1, 1, 0, 1);
    chk("clear count", int'(count), 0);
    chk("clear ovf", int'(overflow), 0);
    step(1, 2, 0, 0);
    chk("post-clear ts", int'(rd_data), int'({4'd0, 2'b10}));
    drain();

    // drop counter saturation
    step(1, 0, 0, 1);
    for (int k = 0; k < 270; k++) step(1, (k % 2 == 0) ? 1 : 0, 0, 0);
    chk("drop sat", int'(drop_count), 255);
    drain();

    // randomized traffic with shifting consumer pressure
    for (int it = 0; it < 1500; it++)
      step($urandom_range(0, 4) != 0, int'($urandom_range(0, 3)),
           $urandom_range(0, 3) < (it / 250) % 4, $urandom_range(0, 63) == 0);
    drain();

    // async reset mid-stream with 5 entries queued
    step(1, 0, 0, 1);
    for (int k = 0; k < 5; k++) step(1, (k % 2 == 0) ? 1 : 0, 0, 0);
    chk("prereset count", int'(count), 5);
    #1 rst_n = 1'b0;
    #1;
    chk("async rd_valid", int'(rd_valid), 0);
    chk("async count", int'(count), 0);
    model_reset();
    @(posedge clk); #1; rst_n = 1'b1;
    step(1, 2, 0, 0);
    chk("post-reset entry", int'(rd_data), int'({4'd0, 2'b10}));
    drain();

    chk("scoreboard empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
